// File: rtl/multi_fir_decimator.sv
// multi_fir_decimator
//   Sums each group of DECIM consecutive input samples into a 36-bit signed
//   accumulator. It saturates the group sum to 32 bits and presents it in a
//   one-deep result register.
//   The result register is an ACCUM/FULL FSM. While FULL, input readiness
//   follows io_out_ready. A stream can therefore drain and refill the
//   register in the same cycle without a bubble.
//
// Ports
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   io_in_ready   block accepts a sample this cycle
//   io_in_valid   upstream offers a sample
//   io_in_bits    32-bit two's-complement sample
//   io_out_ready  downstream takes the result this cycle
//   io_out_valid  result register holds an unconsumed result
//   io_out_bits   saturated sum of DECIM samples
//   io_count      samples accumulated toward the current group
//   io_sat        sticky: some result has clamped since reset

module multi_fir_decimator #(
    parameter int DECIM = 4  // legal range 1..16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        io_in_ready,
    input  logic        io_in_valid,
    input  logic [31:0] io_in_bits,
    input  logic        io_out_ready,
    output logic        io_out_valid,
    output logic [31:0] io_out_bits,
    output logic [3:0]  io_count,
    output logic        io_sat
);

    localparam logic [3:0] LAST = 4'(DECIM - 1);

    typedef enum logic {ACCUM, FULL} state_t;

    state_t             state, state_nxt;
    logic signed [35:0] acc, sum;
    logic [3:0]         cnt;
    logic [31:0]        result, sat_val;
    logic               sat_flag;
    logic               in_fire, out_fire, last;
    logic               clamp_hi, clamp_lo;

    // 36 bits hold 16 full-scale samples, so the sum itself never wraps.
    always_comb begin
        sum      = acc + {{4{io_in_bits[31]}}, io_in_bits};
        // The sum fits 32 bits only when bits 35..31 all agree.
        clamp_hi = !sum[35] && (sum[34:31] != 4'h0);
        clamp_lo =  sum[35] && (sum[34:31] != 4'hF);
        sat_val  = clamp_hi ? 32'h7FFF_FFFF :
                   clamp_lo ? 32'h8000_0000 : sum[31:0];
    end

    assign last     = (cnt == LAST);
    assign in_fire  = io_in_valid && io_in_ready;
    assign out_fire = io_out_valid && io_out_ready;

    // FSM next state and handshake outputs
    always_comb begin
        state_nxt    = state;
        io_in_ready  = 1'b1;
        io_out_valid = 1'b0;
        case (state)
            ACCUM: begin
                if (in_fire && last) state_nxt = FULL;
            end
            FULL: begin
                io_out_valid = 1'b1;
                io_in_ready  = io_out_ready;
                // A completing accept refills the register while the old
                // result leaves, so the FSM stays FULL.
                if (out_fire && !(in_fire && last)) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ACCUM;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            sat_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                if (last) begin
                    result <= sat_val;
                    acc    <= '0;
                    cnt    <= '0;
                    if (clamp_hi || clamp_lo) sat_flag <= 1'b1;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

    assign io_out_bits = result;
    assign io_count    = cnt;
    assign io_sat      = sat_flag;

endmodule

// File: tb/tb_multi_fir_decimator.sv
module tb_multi_fir_decimator;

    typedef struct {
        logic [31:0] bits;
        logic        sat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // one DUT per decimation factor exercised
    logic        ir4, iv4, or4, ov4, st4;
    logic [31:0] ib4, ob4;
    logic [3:0]  cn4;
    logic        ir2, iv2, or2, ov2, st2;
    logic [31:0] ib2, ob2;
    logic [3:0]  cn2;
    logic        ir1, iv1, or1, ov1, st1;
    logic [31:0] ib1, ob1;
    logic [3:0]  cn1;

    multi_fir_decimator #(.DECIM(4)) u_d4 (
        .clk(clk), .reset(reset), .io_in_ready(ir4), .io_in_valid(iv4),
        .io_in_bits(ib4), .io_out_ready(or4), .io_out_valid(ov4),
        .io_out_bits(ob4), .io_count(cn4), .io_sat(st4));
    multi_fir_decimator #(.DECIM(2)) u_d2 (
        .clk(clk), .reset(reset), .io_in_ready(ir2), .io_in_valid(iv2),
        .io_in_bits(ib2), .io_out_ready(or2), .io_out_valid(ov2),
        .io_out_bits(ob2), .io_count(cn2), .io_sat(st2));
    multi_fir_decimator #(.DECIM(1)) u_d1 (
        .clk(clk), .reset(reset), .io_in_ready(ir1), .io_in_valid(iv1),
        .io_in_bits(ib1), .io_out_ready(or1), .io_out_valid(ov1),
        .io_out_bits(ob1), .io_count(cn1), .io_sat(st1));

    exp_t q4[$], q2[$], q1[$];
    int   t1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input string nm, ref exp_t q[$], input logic [31:0] bits, input logic sat);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected got %h expected none", nm, bits);
        end else begin
            e = q.pop_front();
            chk({nm, "_bits"}, bits, e.bits);
            chk({nm, "_sat"}, {31'd0, sat}, {31'd0, e.sat});
        end
    endtask

    // monitor: compare every emitted result against the scoreboard
    always @(negedge clk) begin
        if (!reset && ov4 && or4) pop_chk("d4_out", q4, ob4, st4);
        if (!reset && ov2 && or2) pop_chk("d2_out", q2, ob2, st2);
        if (!reset && ov1 && or1) begin
            t1.push_back(cyc);
            pop_chk("d1_out", q1, ob1, st1);
        end
    end

    function automatic logic rdy(input int s);
        case (s)
            4:       return ir4;
            2:       return ir2;
            default: return ir1;
        endcase
    endfunction

    task automatic drive(input int s, input logic v, input logic [31:0] d);
        case (s)
            4:       begin iv4 = v; ib4 = d; end
            2:       begin iv2 = v; ib2 = d; end
            default: begin iv1 = v; ib1 = d; end
        endcase
    endtask

    // Called just after a rising edge. Returns just after the accepting edge.
    task automatic feed(input int s, input logic [31:0] d);
        bit ok = 0;
        int n  = 0;
        drive(s, 1'b1, d);
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = rdy(s);
            if (!ok) n++;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout_d%0d got not_ready expected ready", s);
        end
        drive(s, 1'b0, 32'h0);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        iv4 = 0; ib4 = 0; or4 = 1;
        iv2 = 0; ib2 = 0; or2 = 1;
        iv1 = 0; ib1 = 0; or1 = 1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_valid", {31'd0, ov4}, 32'd0);
        chk("rst_bits", ob4, 32'd0);
        chk("rst_count", {28'd0, cn4}, 32'd0);
        chk("rst_sat", {31'd0, st4}, 32'd0);
        chk("rst_ready", {31'd0, ir4}, 32'd1);
        chk("rst_ready_d2", {31'd0, ir2}, 32'd1);
        chk("rst_valid_d1", {31'd0, ov1}, 32'd0);
        sync();

        // 1+2+3+4, latency one cycle after the last accept
        q4.push_back('{32'd10, 1'b0});
        feed(4, 1); feed(4, 2); feed(4, 3); feed(4, 4);
        @(negedge clk);
        chk("lat_valid", {31'd0, ov4}, 32'd1);
        chk("lat_bits", ob4, 32'd10);
        chk("lat_count", {28'd0, cn4}, 32'd0);
        chk("lat_sat", {31'd0, st4}, 32'd0);
        sync();

        // positive clamp, then sticky flag on an unsaturated group
        q4.push_back('{32'h7FFF_FFFF, 1'b1});
        repeat (4) feed(4, 32'h4000_0000);
        q4.push_back('{32'd4, 1'b1});
        repeat (4) feed(4, 32'd1);
        @(negedge clk);
        chk("sticky_sat", {31'd0, st4}, 32'd1);
        sync();

        // negative clamp, then -4 unclamped
        q4.push_back('{32'h8000_0000, 1'b1});
        repeat (4) feed(4, 32'hC000_0001);
        q4.push_back('{32'hFFFF_FFFC, 1'b1});
        repeat (4) feed(4, 32'hFFFF_FFFF);
        sync();

        // reset mid-group discards the partial sum
        feed(4, 1); feed(4, 2);
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_count", {28'd0, cn4}, 32'd0);
        chk("midrst_valid", {31'd0, ov4}, 32'd0);
        chk("midrst_sat", {31'd0, st4}, 32'd0);
        sync();

        // reset while FULL discards the pending result
        or4 = 1'b0;
        repeat (4) feed(4, 32'd9);
        @(negedge clk);
        chk("full_valid", {31'd0, ov4}, 32'd1);
        sync();
        reset = 1'b1;
        sync();
        reset = 1'b0;
        or4 = 1'b1;
        @(negedge clk);
        chk("fullrst_valid", {31'd0, ov4}, 32'd0);
        sync();
        q4.push_back('{32'd4, 1'b0});
        repeat (4) feed(4, 32'd1);
        sync(); sync();

        // DECIM=2 backpressure; the pending input must not be taken
        or2 = 1'b0;
        q2.push_back('{32'd11, 1'b0});
        feed(2, 5); feed(2, 6);
        drive(2, 1'b1, 32'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, ov2}, 32'd1);
            chk("stall_bits", ob2, 32'd11);
            chk("stall_ready", {31'd0, ir2}, 32'd0);
            chk("stall_count", {28'd0, cn2}, 32'd0);
        end
        sync();
        or2 = 1'b1;
        sync();
        drive(2, 1'b0, 32'd0);
        @(negedge clk);
        chk("drain_valid", {31'd0, ov2}, 32'd0);
        chk("drain_count", {28'd0, cn2}, 32'd1);
        sync();
        q2.push_back('{32'd15, 1'b0});
        feed(2, 8);
        sync(); sync();

        // DECIM=1 streaming without a bubble
        q1.push_back('{32'd3, 1'b0});
        q1.push_back('{32'd5, 1'b0});
        q1.push_back('{32'd9, 1'b0});
        feed(1, 3); feed(1, 5); feed(1, 9);
        sync(); sync();

        chk("d1_outputs", t1.size(), 32'd3);
        if (t1.size() == 3) begin
            chk("d1_gap0", t1[1] - t1[0], 32'd1);
            chk("d1_gap1", t1[2] - t1[1], 32'd1);
        end
        chk("q4_drained", q4.size(), 32'd0);
        chk("q2_drained", q2.size(), 32'd0);
        chk("q1_drained", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
